// File: rtl/hazard_fwd_unit.sv
//------------------------------------------------------------------------------
// Module      : hazard_fwd_unit
// Description : Shift-register scoreboard of in-flight register writers that
//               drives operand forwarding selects and the load-use stall.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hazard_fwd_unit #(
   parameter int ADDR_W     = 5,
   parameter int FWD_STAGES = 3,
   parameter int ZERO_REG   = 31,
   parameter int LINK_REG   = 30,
   parameter int LOAD_STAGE = 2,
   localparam int SEL_W     = $clog2(FWD_STAGES + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [ADDR_W-1:0] id_rs1,
   input  logic [ADDR_W-1:0] id_rs2,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   input  logic [ADDR_W-1:0] id_rd,
   input  logic              id_regwrite,
   input  logic              id_is_load,
   input  logic              id_link,
   input  logic              flush,
   input  logic              hold,
   output logic              stall_out,
   output logic [SEL_W-1:0]  fwd_a,
   output logic [SEL_W-1:0]  fwd_b,
   output logic [SEL_W-1:0]  inflight_cnt
);

   localparam logic [ADDR_W-1:0] C_ZERO_IDX = ADDR_W'(ZERO_REG);
   localparam logic [ADDR_W-1:0] C_LINK_IDX = ADDR_W'(LINK_REG);

   logic [FWD_STAGES:1] r_valid;
   logic [FWD_STAGES:1] r_load;
   logic [ADDR_W-1:0]   r_dest [1:FWD_STAGES];
   logic [SEL_W-1:0]    r_cnt;

   logic [ADDR_W-1:0]   w_dest;
   logic                w_record;
   logic                w_enter;
   logic                w_chk_a;
   logic                w_chk_b;
   logic                w_haz_a;
   logic                w_haz_b;
   logic [SEL_W-1:0]    w_sel_a;
   logic [SEL_W-1:0]    w_sel_b;
   logic [FWD_STAGES:1] w_next_valid;
   logic [SEL_W-1:0]    w_next_cnt;

   assign w_dest   = id_link ? C_LINK_IDX : id_rd;
   assign w_record = (id_link | id_regwrite) & (id_link | (w_dest != C_ZERO_IDX));
   assign w_chk_a  = id_rs1_used & (id_rs1 != C_ZERO_IDX);
   assign w_chk_b  = id_rs2_used & (id_rs2 != C_ZERO_IDX);

   // Scan oldest to youngest so the youngest matching writer overrides.
   always_comb begin
      w_sel_a = '0;
      w_haz_a = 1'b0;
      w_sel_b = '0;
      w_haz_b = 1'b0;
      for (int k = FWD_STAGES; k >= 1; k--) begin
         if (w_chk_a && r_valid[k] && (r_dest[k] == id_rs1)) begin
            w_haz_a = r_load[k] && (k < LOAD_STAGE);
            w_sel_a = w_haz_a ? '0 : SEL_W'(k);
         end
         if (w_chk_b && r_valid[k] && (r_dest[k] == id_rs2)) begin
            w_haz_b = r_load[k] && (k < LOAD_STAGE);
            w_sel_b = w_haz_b ? '0 : SEL_W'(k);
         end
      end
   end

   assign stall_out = id_valid & ~flush & ~hold & (w_haz_a | w_haz_b);
   assign fwd_a     = id_valid ? w_sel_a : '0;
   assign fwd_b     = id_valid ? w_sel_b : '0;

   // A stall or flush turns the decode slot into a bubble.
   assign w_enter      = id_valid & ~flush & ~stall_out & w_record;
   assign w_next_valid = {r_valid[FWD_STAGES-1:1], w_enter};

   always_comb begin
      w_next_cnt = '0;
      for (int k = 1; k <= FWD_STAGES; k++) begin
         w_next_cnt = w_next_cnt + SEL_W'(w_next_valid[k]);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_valid <= '0;
         r_cnt   <= '0;
      end else if (!hold) begin
         r_valid <= w_next_valid;
         r_cnt   <= w_next_cnt;
      end
   end

   // Payload fields are only meaningful where the matching valid bit is set.
   always_ff @(posedge clk) begin
      if (!hold) begin
         r_load    <= {r_load[FWD_STAGES-1:1], id_is_load};
         r_dest[1] <= w_dest;
         for (int k = 2; k <= FWD_STAGES; k++) begin
            r_dest[k] <= r_dest[k-1];
         end
      end
   end

   assign inflight_cnt = r_cnt;

endmodule

`default_nettype wire

// File: doc/hazard_fwd_unit.md
# hazard_fwd_unit

Parametrised hazard-detection and operand-forwarding unit for the pipelined CPU. It tracks every in-flight register writer in a shift-register scoreboard, including link-register writes from BL. From that it drives forwarding selects for both decode-stage read operands and raises a load-use stall when a result is not yet available. It replaces the hard-wired two-stage forwarding logic with configurable depth, register-file size, load latency, pipeline freeze and flush.

## Interface
Parameters:
- ADDR_W, 5, register index width
- FWD_STAGES, 3, in-flight stages that can forward (1 = EX, 2 = MEM, 3 = WB); must be ≥ 2
- ZERO_REG, 31, hard-wired zero register: never forwarded, never recorded
- LINK_REG, 30, destination used when id_link = 1
- LOAD_STAGE, 2, first stage index at which load data can be forwarded; range 1..FWD_STAGES

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low; state clears on a rising clk edge while reset = 0
- id_valid  in  1  decode stage holds a real instruction
- id_rs1, id_rs2  in  ADDR_W  source indices
- id_rs1_used, id_rs2_used  in  1  the corresponding source is read
- id_rd  in  ADDR_W  destination index
- id_regwrite  in  1  instruction writes id_rd
- id_is_load  in  1  result comes from data memory
- id_link  in  1  instruction writes LINK_REG; overrides id_rd and id_regwrite
- flush  in  1  squash the decode instruction (taken branch)
- hold  in  1  freeze the whole pipeline (scoreboard does not advance)
- stall_out  out  1  decode must hold; a bubble is inserted into stage 1
- fwd_a, fwd_b  out  $clog2(FWD_STAGES+1)  operand source: 0 = regfile, k = stage k result
- inflight_cnt  out  $clog2(FWD_STAGES+1)  number of valid entries in the scoreboard

## Operation
- The scoreboard holds entries e[1..FWD_STAGES], each {valid, dest, is_load}. e[1] is the instruction one cycle past decode.
- Decode destination: dest = id_link ? LINK_REG : id_rd.
  - The instruction writes when id_link | id_regwrite.
  - It is recorded only if it writes and (id_link | dest ≠ ZERO_REG).
- Operand lookup, applied separately to rs1 → fwd_a and rs2 → fwd_b:
  - If the source is unused or equals ZERO_REG, the select is 0 and no hazard is raised.
  - Otherwise find the smallest k (youngest writer) with e[k].valid and e[k].dest == source.
  - No match: select 0.
  - Match where e[k].is_load and k < LOAD_STAGE: hazard is raised and the select is 0.
  - Match otherwise: select is k.
  - Older matches are ignored once a younger one is found.
- stall_out = id_valid & ~flush & ~hold & (hazard_a | hazard_b).
- fwd_a and fwd_b are 0 whenever id_valid = 0.
- Writes from the stage after FWD_STAGES are not forwarded. The regfile writes on the inverted clock, so those values are readable in the same cycle.
- Advance rule, evaluated at the clock edge:
  - reset = 0: all entries are cleared to invalid and inflight_cnt goes to 0.
  - Otherwise, if hold = 1: the scoreboard and inflight_cnt keep their values.
  - Otherwise: e[k+1] ← e[k] for each k, and e[FWD_STAGES] is discarded. e[1] ← the decode entry if id_valid & ~flush & ~stall_out & it is recorded; otherwise e[1] ← bubble (valid = 0).
- inflight_cnt is a register equal to the popcount of valid entries after each update.

## Timing
- stall_out, fwd_a and fwd_b are combinational from the current scoreboard and the id_* inputs, so they are valid in the same cycle. There is no added latency.
- The scoreboard updates on the rising clk edge, giving a one-cycle shift per unfrozen cycle.
- Load-use penalty is (LOAD_STAGE − k) stall cycles for a consumer whose producer currently sits in stage k. With defaults, a load followed immediately by a dependent instruction costs exactly 1 stall cycle, then fwd = 2.
- Reset:
  - After any edge with reset = 0: inflight_cnt = 0 and every entry is invalid.
  - Consequently stall_out = 0 and fwd_a/fwd_b = 0 for any inputs until new writers enter.
  - Reset mid-operation discards all in-flight writers.
- Simultaneous events:
  - hold beats flush and stall: nothing shifts and stall_out = 0.
  - flush beats stall: a bubble is inserted and stall_out = 0.
  - A stall always inserts a bubble, so a stall cannot persist beyond LOAD_STAGE − 1 cycles without hold.
- Two identical destinations in flight: the youngest wins.

## Test plan
- ADD X1 then ADD X2,X1,X1 on consecutive cycles → next cycle fwd_a = fwd_b = 1, stall_out = 0; one cycle later the same pair gives fwd = 2; after FWD_STAGES cycles, fwd = 0.
- LDUR X3 then SUB X4,X3,X5 → stall_out = 1 for exactly 1 cycle, inflight_cnt 1→1 with a bubble in e[1]; the next cycle fwd_a = 2 and stall_out = 0.
- BL (id_link = 1, id_rd = 5) followed by a read of X30 → fwd = 1. A read of X5 → fwd = 0. A write to X31 with id_link = 0 → never recorded, inflight_cnt unchanged.
- ADD X1 at cycle t and ADD X1 at cycle t+1, then read X1 → fwd = 1 (youngest), not 2.
- hold = 1 for 3 cycles with a load in e[1] and the dependent in decode → scoreboard frozen, stall_out = 0 throughout. After hold drops, stall_out = 1 for 1 cycle. With flush = 1 on the same cycle as a would-be stall → stall_out = 0 and the entry is not recorded.
- Fill the scoreboard (inflight_cnt = 3), drive reset = 0 for one edge → inflight_cnt = 0 and a dependent read gives fwd = 0, stall = 0. Repeat with FWD_STAGES = 4, LOAD_STAGE = 3 → load-use costs 2 stall cycles.
